ring_bridge_injector: RTL

//  Drain side of a ring-to-ring transfer buffer. Pops flits from the peer connect router's transfer FIFO.

---
 rtl/ring_bridge_injector_if.sv | 24 ++
 rtl/ring_bridge_injector.sv | 72 +++++++
 2 files changed

// File: rtl/ring_bridge_injector_if.sv
// Bundles the ring ports and the peer transfer-FIFO handshake of ring_bridge_injector.
// The master modport is the environment side; the slave modport is the injector.
interface ring_bridge_injector_if #(
  parameter int CONTROL_W = 16
) ();
  logic [CONTROL_W-1:0] port_in;
  logic [CONTROL_W-1:0] port_out;
  logic [CONTROL_W-1:0] xfer_flit;
  logic [2:0]           xfer_size;
  logic                 xfer_pop;
  logic                 injected;
  logic                 starved;
  logic [15:0]          inj_count;

  modport master (
    output port_in, xfer_flit, xfer_size,
    input  port_out, xfer_pop, injected, starved, inj_count
  );

  modport slave (
    input  port_in, xfer_flit, xfer_size,
    output port_out, xfer_pop, injected, starved, inj_count
  );
endinterface

// File: rtl/ring_bridge_injector.sv
// Drains a peer ring's transfer FIFO into a one-entry staging register.
// The staged flit is injected into empty slots of a two-stage ring pipeline.
module ring_bridge_injector #(
  parameter int CONTROL_W    = 16,
  parameter int VALID_F      = 15,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ring_bridge_injector_if.slave bus
);

  logic [CONTROL_W-1:0] ring_r0_q, ring_r0_d;
  logic [CONTROL_W-1:0] ring_r1_q, ring_r1_d;
  logic [CONTROL_W-1:0] stg_q, stg_d;
  logic                 stg_valid_q, stg_valid_d;
  logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic [15:0]          inj_count_q, inj_count_d;
  logic                 inj;
  logic                 pop;

  // A valid ring flit always wins the slot; staging may refill in the same cycle it injects.
  always_comb begin
    inj          = stg_valid_q & ~ring_r0_q[VALID_F];
    pop          = ~rst & (bus.xfer_size != 3'd0) & (~stg_valid_q | inj);
    ring_r0_d    = bus.port_in;
    ring_r1_d    = inj ? stg_q : ring_r0_q;
    stg_d        = stg_q;
    stg_valid_d  = stg_valid_q;
    starve_cnt_d = starve_cnt_q;
    inj_count_d  = inj_count_q + {15'd0, inj};

    if (pop) begin
      stg_d       = bus.xfer_flit;
      stg_valid_d = 1'b1;
    end else if (inj) begin
      stg_valid_d = 1'b0;
    end

    if (!stg_valid_q || inj) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != {CNT_W{1'b1}}) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_r0_q    <= '0;
      ring_r1_q    <= '0;
      stg_q        <= '0;
      stg_valid_q  <= 1'b0;
      starve_cnt_q <= '0;
      inj_count_q  <= '0;
    end else begin
      ring_r0_q    <= ring_r0_d;
      ring_r1_q    <= ring_r1_d;
      stg_q        <= stg_d;
      stg_valid_q  <= stg_valid_d;
      starve_cnt_q <= starve_cnt_d;
      inj_count_q  <= inj_count_d;
    end
  end

  assign bus.port_out  = ring_r1_q;
  assign bus.xfer_pop  = pop;
  assign bus.injected  = inj;
  assign bus.starved   = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));
  assign bus.inj_count = inj_count_q;

endmodule
